onehot_rr_arbiter: RTL

Round-robin arbiter that shares one downstream resource between `NUM_REQ` requesters and drives a registered one-hot grant vector. A granted requester keeps ownership while it requests, up to a bounded tenure, and then ownership rotates. It sits in front of any shared datapath that needs exactly one active owner. An optional self-check flags any grant vector that is neither zero nor one-hot.

---
 rtl/onehot_rr_arbiter.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/onehot_rr_arbiter.sv
// -----------------------------------------------------------------------------
// onehot_rr_arbiter
//
// Round-robin arbiter that hands one shared resource to one of NUM_REQ
// requesters. The owner keeps the grant while it requests, for at most
// MAX_HOLD consecutive cycles when someone else is waiting, and then
// ownership rotates. Handover happens on a single edge with no idle bubble.
//
// Parameters:
//   NUM_REQ   number of requesters (2..32)
//   MAX_HOLD  max consecutive cycles per owner while others wait (>= 1)
//
// Ports:
//   clk          clock, rising edge
//   resetn       synchronous active-low reset
//   req          level-sensitive request lines
//   grant        registered grant, all-zero or one-hot
//   grant_valid  high when grant is nonzero
//   grant_id     index of the current owner, 0 when grant_valid is low
//   onehot_err   sticky flag from the grant self-check
//
// Build option:
//   ONEHOT_ARB_CHECK_EN  when defined, a population-count checker watches the
//                        registered grant and sets onehot_err on any illegal
//                        value. When undefined onehot_err is tied low.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | nobody owns the resource, grant is zero
// OWNED | grant_id owns the resource, hold_cnt counts its tenure
// -----------------------------------------------------------------------------
module onehot_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       onehot_err
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    localparam logic [PTR_W:0]     NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W:0]     ONE_W     = (PTR_W + 1)'(1);
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [NUM_REQ-1:0] GRANT_ONE = NUM_REQ'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [PTR_W-1:0]     grant_id_q, grant_id_d;

    // Winner search signals
    logic [NUM_REQ-1:0]   cand;
    logic [NUM_REQ-1:0]   rot;
    logic                 win_found;
    logic [PTR_W-1:0]     win_off;
    logic [PTR_W:0]       sum_idx;
    logic [PTR_W:0]       sum_next;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W-1:0]     win_next;

    // Owner status
    logic                 owner_req;
    logic                 others_req;
    logic                 tenure_last;
    logic                 release_now;

    // -------------------------------------------------------------------------
    // Winner selection. Candidates exclude the current owner: when the owner
    // dropped its request it is already absent from req, and on tenure expiry
    // it must be skipped, so one mask covers both release causes. In IDLE the
    // grant is zero and the mask is a no-op.
    // The scan rotates the candidates right by ptr so that bit 0 of rot is
    // index ptr, takes the lowest set bit, and maps back modulo NUM_REQ.
    // -------------------------------------------------------------------------
    always_comb begin
        cand      = req & ~grant_q;
        rot       = NUM_REQ'({cand, cand} >> ptr_q);
        win_found = 1'b0;
        win_off   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                win_found = 1'b1;
                win_off   = PTR_W'(i);
            end
        end

        sum_idx = {1'b0, ptr_q} + {1'b0, win_off};
        if (sum_idx >= NUM_REQ_W) begin
            sum_idx = sum_idx - NUM_REQ_W;
        end
        win_idx = sum_idx[PTR_W-1:0];

        sum_next = {1'b0, win_idx} + ONE_W;
        if (sum_next >= NUM_REQ_W) begin
            sum_next = sum_next - NUM_REQ_W;
        end
        win_next = sum_next[PTR_W-1:0];
    end

    always_comb begin
        owner_req   = |(req & grant_q);
        others_req  = |cand;
        tenure_last = (hold_cnt_q == HOLD_LAST);
        release_now = !owner_req || (tenure_last && others_req);
    end

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;

        unique case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (win_found) begin
                    state_d       = OWNED;
                    grant_d       = GRANT_ONE << win_idx;
                    grant_valid_d = 1'b1;
                    grant_id_d    = win_idx;
                    ptr_d         = win_next;
                end else begin
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    grant_id_d    = '0;
                end
            end

            OWNED: begin
                if (release_now) begin
                    hold_cnt_d = '0;
                    if (win_found) begin
                        grant_d       = GRANT_ONE << win_idx;
                        grant_valid_d = 1'b1;
                        grant_id_d    = win_idx;
                        ptr_d         = win_next;
                    end else begin
                        state_d       = IDLE;
                        grant_d       = '0;
                        grant_valid_d = 1'b0;
                        grant_id_d    = '0;
                    end
                end else if (tenure_last) begin
                    // Tenure used up but nobody else is asking: keep the
                    // grant and start a fresh tenure.
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d       = IDLE;
                grant_d       = '0;
                grant_valid_d = 1'b0;
                grant_id_d    = '0;
                hold_cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;

    // -------------------------------------------------------------------------
    // Grant self-check
    // -------------------------------------------------------------------------
`ifdef ONEHOT_ARB_CHECK_EN
    logic [PTR_W:0] pop_cnt;
    logic           onehot_err_q, onehot_err_d;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pop_cnt = pop_cnt + (PTR_W + 1)'(grant_q[i]);
        end
        onehot_err_d = onehot_err_q
                     | (pop_cnt > ONE_W)
                     | (grant_valid_q != (pop_cnt == ONE_W));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            onehot_err_q <= 1'b0;
        end else begin
            onehot_err_q <= onehot_err_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (resetn && onehot_err_d && !onehot_err_q) begin
            $error("onehot_rr_arbiter: illegal grant %b (valid=%b)", grant_q, grant_valid_q);
        end
    end
`endif

    assign onehot_err = onehot_err_q;
`else
    assign onehot_err = 1'b0;
`endif

endmodule
